// File: rtl/hybrid_adder_pkg.sv
// Shared defaults for the hybrid ripple-block / carry-lookahead adder.
// Also provides the block-count helper used by the top level.
package hybrid_adder_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefBlk   = 4;

    function automatic int unsigned num_blocks(input int unsigned width, input int unsigned blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational carry-lookahead block: every internal carry is a flat sum of
// products of the generate/propagate terms and cin.
module cla_block #(
    parameter int unsigned BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK-1:0] carry;
    logic           grp_g;
    logic           grp_p;

    assign g = a & b;
    assign p = a ^ b;

    // carry[i] = OR_j (g[j] & p[j+1..i-1]) | (cin & p[0..i-1])
    always_comb begin
        logic ci;
        logic pp;
        carry = '0;
        for (int i = 0; i < BLK; i++) begin
            ci = 1'b0;
            for (int j = 0; j < i; j++) begin
                pp = 1'b1;
                for (int k = j + 1; k < i; k++) begin
                    pp = pp & p[k];
                end
                ci = ci | (g[j] & pp);
            end
            pp = 1'b1;
            for (int k = 0; k < i; k++) begin
                pp = pp & p[k];
            end
            carry[i] = ci | (cin & pp);
        end
    end

    always_comb begin
        logic pp;
        grp_g = 1'b0;
        for (int j = 0; j < BLK; j++) begin
            pp = 1'b1;
            for (int k = j + 1; k < BLK; k++) begin
                pp = pp & p[k];
            end
            grp_g = grp_g | (g[j] & pp);
        end
        grp_p = &p;
    end

    assign s    = p ^ carry;
    assign cout = grp_g | (grp_p & cin);

endmodule

// File: rtl/hybrid_adder.sv
// Registered 32-bit adder: lookahead blocks with block carries rippled between
// them, sum and carry-out captured each rising edge with synchronous reset.
module hybrid_adder
    import hybrid_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned BLK   = DefBlk
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic [WIDTH-1:0] out,
    output logic             c
);

    localparam int unsigned NBLK = num_blocks(WIDTH, BLK);

    logic [NBLK:0]    blk_carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] out_q;
    logic             c_q;

    assign blk_carry[0] = 1'b0;

    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
        cla_block #(
            .BLK (BLK)
        ) u_cla (
            .a    (inp1[gi*BLK +: BLK]),
            .b    (inp2[gi*BLK +: BLK]),
            .cin  (blk_carry[gi]),
            .s    (sum_d[gi*BLK +: BLK]),
            .cout (blk_carry[gi+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            c_q   <= 1'b0;
        end else begin
            out_q <= sum_d;
            c_q   <= blk_carry[NBLK];
        end
    end

    assign out = out_q;
    assign c   = c_q;

endmodule

// File: tb/tb_hybrid_adder.sv
// Directed-vector and random self-checking bench for hybrid_adder.
module tb_hybrid_adder;

    logic        clk;
    logic        rst;
    logic [31:0] inp1;
    logic [31:0] inp2;
    logic [31:0] out;
    logic        c;

    int tests;
    int fails;

    hybrid_adder u_dut (
        .clk  (clk),
        .rst  (rst),
        .inp1 (inp1),
        .inp2 (inp2),
        .out  (out),
        .c    (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_c;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {c,out}=%0h required %0h", name, got, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the capturing edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst  = r;
        inp1 = a;
        inp2 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        inp1 = '0;
        inp2 = '0;
        tests = 0;
        fails = 0;

        vecs[0] = '{"all_ones_plus_1",  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[1] = '{"not5_plus_1",      32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFB, 1'b0};
        vecs[2] = '{"blk_boundary",     32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 1'b0};
        vecs[3] = '{"max_plus_max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vecs[4] = '{"signed_ovf_no_c",  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[5] = '{"zero_plus_zero",   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{"mixed_digits",     32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
        vecs[7] = '{"msb_plus_msb",     32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[8] = '{"half_carry",       32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};
        vecs[9] = '{"long_propagate",   32'hF0F0_F0F0, 32'h0F0F_0F10, 32'h0000_0000, 1'b1};

        step(1'b1, 32'h0, 32'h0);
        check("reset_state", {c, out}, 33'h0);

        foreach (vecs[i]) begin
            step(1'b0, vecs[i].a, vecs[i].b);
            check(vecs[i].name, {c, out}, {vecs[i].exp_c, vecs[i].exp_out});
        end

        // Reset wins over capture at the same edge, then 3+4 shows up next edge.
        step(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        check("pre_reset_value", {c, out}, {1'b1, 32'h0});
        step(1'b1, 32'd3, 32'd4);
        check("reset_priority", {c, out}, 33'h0);
        step(1'b0, 32'd3, 32'd4);
        check("post_reset_sum", {c, out}, 33'd7);

        // Mid-stream reset drops the result that would have been captured.
        step(1'b0, 32'h1111_1111, 32'h2222_2222);
        check("stream_before_rst", {c, out}, 33'h0_3333_3333);
        step(1'b1, 32'hFFFF_0000, 32'h0001_0000);
        check("midstream_reset", {c, out}, 33'h0);

        // Back-to-back random operands, checked against the 33-bit sum.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [32:0] ref_sum;
            a = $urandom;
            b = $urandom;
            if (n % 17 == 0) a = 32'hFFFF_FFFF;
            ref_sum = {1'b0, a} + {1'b0, b};
            step(1'b0, a, b);
            check("random", {c, out}, ref_sum);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
